keypad_scan_ctrl: RTL

Column-scanning controller for the 4x4 matrix keypad. It drives one column low at a time and samples the raw active-low row lines through a synchronizer. It debounces press and release, then emits a single-cycle `key_valid` strobe with a hex key code for each press. It sits between the keypad pins (`rows`/`cols`) and the two-digit display history logic in `top2`, replacing ad-hoc scanning with one locked, single-key FSM.

---
 rtl/keypad_pkg.sv | 33 +++
 rtl/keypad_scan_ctrl_sync2.sv | 28 ++
 rtl/keypad_scan_ctrl.sv | 122 ++++++++++++
 3 files changed

// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad column scanner.
// Key map is indexed [row][col]; columns are driven active-low.
package keypad_pkg;

   typedef enum logic [1:0] {
      SCAN     = 2'd0,
      DEBOUNCE = 2'd1,
      HELD     = 2'd2,
      RELEASE  = 2'd3
   } scan_state_t;

   localparam logic [3:0] COLS_RESET = 4'b1110;

   localparam logic [3:0] KEY_MAP [4][4] = '{
      '{4'h1, 4'h2, 4'h3, 4'hA},
      '{4'h4, 4'h5, 4'h6, 4'hB},
      '{4'h7, 4'h8, 4'h9, 4'hC},
      '{4'hE, 4'h0, 4'hF, 4'hD}
   };

   // Lowest-index low row wins when several rows are shorted at once.
   function automatic logic [1:0] low_row(input logic [3:0] r);
      if (!r[0])      return 2'd0;
      else if (!r[1]) return 2'd1;
      else if (!r[2]) return 2'd2;
      else            return 2'd3;
   endfunction

   function automatic logic [3:0] col_drive(input logic [1:0] idx);
      return ~(4'b0001 << idx);
   endfunction

endpackage

// File: rtl/keypad_scan_ctrl_sync2.sv
// Two-flop synchronizer for the asynchronous keypad row lines.
// Reset value is a parameter so idle (all-high) rows read as "no key".
module sync2 #(
   parameter int              W       = 4,
   parameter logic [W-1:0]    RST_VAL = '1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] q_o
);

   logic [W-1:0] meta_q;
   logic [W-1:0] sync_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= RST_VAL;
         sync_q <= RST_VAL;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/keypad_scan_ctrl.sv
// Column-scanning 4x4 keypad controller: one-key-at-a-time FSM with press
// and release debounce, emitting a single-cycle strobe and hex code per press.
module keypad_scan_ctrl
   import keypad_pkg::*;
#(
   parameter int SCAN_CYCLES     = 4800,
   parameter int DEBOUNCE_CYCLES = 960000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] rows,
   output logic [3:0] cols,
   output logic       key_valid,
   output logic [3:0] key_code,
   output logic       key_held
);

   localparam int SW = $clog2(SCAN_CYCLES);
   localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_CYCLES - 1);
   localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);

   scan_state_t   state_q;
   logic [1:0]    col_idx_q;
   logic [1:0]    row_idx_q;
   logic [SW-1:0] dwell_q;
   logic [DW-1:0] deb_q;
   logic [3:0]    cols_q;
   logic          key_valid_q;
   logic [3:0]    key_code_q;
   logic          key_held_q;

   logic [3:0]    rows_s;
   logic          row_bit;
   logic [1:0]    col_nxt;

   sync2 #(.W(4), .RST_VAL(4'b1111)) u_sync (
      .clk   (clk),
      .rst_n (reset),
      .d_i   (rows),
      .q_o   (rows_s)
   );

   assign row_bit = rows_s[row_idx_q];
   assign col_nxt = col_idx_q + 2'd1;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= SCAN;
         col_idx_q   <= 2'd0;
         row_idx_q   <= 2'd0;
         dwell_q     <= '0;
         deb_q       <= '0;
         cols_q      <= COLS_RESET;
         key_valid_q <= 1'b0;
         key_code_q  <= 4'h0;
         key_held_q  <= 1'b0;
      end else begin
         key_valid_q <= 1'b0;
         case (state_q)
            SCAN: begin
               // Rows are only trusted on the last dwell cycle of a column.
               if (dwell_q == SCAN_LAST) begin
                  dwell_q <= '0;
                  if (rows_s == 4'b1111) begin
                     col_idx_q <= col_nxt;
                     cols_q    <= col_drive(col_nxt);
                  end else begin
                     row_idx_q <= low_row(rows_s);
                     deb_q     <= '0;
                     state_q   <= DEBOUNCE;
                  end
               end else begin
                  dwell_q <= dwell_q + SW'(1);
               end
            end
            DEBOUNCE: begin
               if (row_bit) begin
                  col_idx_q <= col_nxt;
                  cols_q    <= col_drive(col_nxt);
                  dwell_q   <= '0;
                  state_q   <= SCAN;
               end else if (deb_q == DEB_LAST) begin
                  key_valid_q <= 1'b1;
                  key_code_q  <= KEY_MAP[row_idx_q][col_idx_q];
                  key_held_q  <= 1'b1;
                  state_q     <= HELD;
               end else begin
                  deb_q <= deb_q + DW'(1);
               end
            end
            HELD: begin
               if (row_bit) begin
                  deb_q   <= '0;
                  state_q <= RELEASE;
               end
            end
            RELEASE: begin
               // A re-press during release debounce goes back to HELD silently.
               if (!row_bit) begin
                  state_q <= HELD;
               end else if (deb_q == DEB_LAST) begin
                  key_held_q <= 1'b0;
                  col_idx_q  <= col_nxt;
                  cols_q     <= col_drive(col_nxt);
                  dwell_q    <= '0;
                  state_q    <= SCAN;
               end else begin
                  deb_q <= deb_q + DW'(1);
               end
            end
            default: state_q <= SCAN;
         endcase
      end
   end

   assign cols      = cols_q;
   assign key_valid = key_valid_q;
   assign key_code  = key_code_q;
   assign key_held  = key_held_q;

endmodule
